sram_req_ctrl: RTL and testbench



---
 rtl/sram_req_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl
//   Request-side controller for a 256x8 asynchronous-read SRAM. Commands come
//   in on a valid/ready request channel. The controller drives the SRAM pins,
//   captures read data and returns one response per read beat, or one per
//   write command, on a valid/ready response channel.
//
//   Handshake rule (both channels): a transfer happens on a rising edge where
//   valid && ready are both 1. Once raised, a producer holds valid and its
//   payload stable until that transfer.
//
//   Optional feature: define SRAM_REQ_CTRL_BURST_EN to honour req_len, which
//   expands one command into req_len+1 beats at consecutive addresses, wrapping
//   modulo 2^ADDR_W. When it is undefined, every command is one beat.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   command channel; req_write, req_addr, req_wdata, req_len
//   rsp_valid/ready   response channel; rsp_rdata (0 for writes), rsp_last
//   mem_address, mem_data_in, mem_read_write, mem_chip_en   to the SRAM
//   mem_data_out      from the SRAM, combinational from mem_address
//
// The FSM state is held in state_q (type state_t) and can be probed
// hierarchically.
module sram_req_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_write,
  output logic              mem_chip_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_WGAP = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic [LEN_W-1:0]  cnt_q;
  logic              last_beat;

`ifdef SRAM_REQ_CTRL_BURST_EN
  logic [LEN_W-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // Single-beat build: the remaining-beat count is pinned at zero so every
  // command ends after its first beat.
  logic unused_req_len;
  assign cnt_q          = '0;
  assign unused_req_len = ^req_len;
`endif

  assign last_beat = (cnt_q == '0);

  // Response side is decoded from registered state only.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_last  = rsp_valid && (last_beat || write_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
`ifdef SRAM_REQ_CTRL_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
`ifdef SRAM_REQ_CTRL_BURST_EN
          cnt_d   = req_len;
`endif
          state_d = req_write ? S_WR : S_RD;
        end
      end
      S_RD: begin
        // SRAM read is asynchronous: the word is valid by the end of the cycle.
        rdata_d = mem_data_out;
        state_d = S_RSP;
      end
      S_WR: begin
        state_d = S_WGAP;
      end
      S_WGAP: begin
        if (!last_beat) begin
          addr_d  = addr_q + 1'b1;
`ifdef SRAM_REQ_CTRL_BURST_EN
          cnt_d   = cnt_q - 1'b1;
`endif
          state_d = S_WR;
        end else begin
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
`ifdef SRAM_REQ_CTRL_BURST_EN
            cnt_d   = cnt_q - 1'b1;
`endif
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The SRAM pins come straight from flops loaded from the next state, so
  // they cannot glitch. Address/data only move on the edge entering WR (when
  // chip_en was low in WGAP) and are held through WR into WGAP, so they never
  // change while the level-sensitive write is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      write_q        <= 1'b0;
      rdata_q        <= '0;
      mem_address    <= '0;
      mem_data_in    <= '0;
      mem_read_write <= 1'b0;
      mem_chip_en    <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      write_q        <= write_d;
      rdata_q        <= rdata_d;
      mem_chip_en    <= (state_d == S_RD) || (state_d == S_WR);
      mem_read_write <= (state_d == S_WR);
      mem_address    <= ((state_d == S_RD) || (state_d == S_WR) || (state_d == S_WGAP))
                        ? addr_d : '0;
      mem_data_in    <= ((state_d == S_WR) || (state_d == S_WGAP)) ? wdata_d : '0;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: a behavioural 256x8 SRAM, a table of command
// vectors with expected latency / first data, a response scoreboard fed from a
// reference memory image, hand-written reset sequences and a pin-timing
// monitor on the SRAM write strobe.
module tb_sram_req_ctrl;

`ifdef SRAM_REQ_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic [3:0] req_len;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_read_write, mem_chip_en;

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write), .mem_chip_en(mem_chip_en),
    .mem_data_out(mem_data_out)
  );

  // ---------------- SRAM model and reference image ----------------
  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = init_val(8'(i));
      ref_mem[i] = init_val(8'(i));
    end
  end

  always @(posedge clk) if (mem_chip_en && mem_read_write) sram[mem_address] <= mem_data_in;
  assign mem_data_out = sram[mem_address];

  // ---------------- pin-timing monitor ----------------
  // After a write-strobe cycle, the next cycle must have the strobe low and
  // the same address/data on the pins.
  int   viol = 0;
  logic prev_we = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_a = '0, prev_d = '0;

  always @(posedge clk) begin
    if (!rst && !prev_rst && prev_we) begin
      if (mem_chip_en && mem_read_write) begin
        viol++;
        $display("monitor: back-to-back write strobe at %0t", $time);
      end
      if (mem_address !== prev_a || mem_data_in !== prev_d) begin
        viol++;
        $display("monitor: pins moved after write strobe at %0t", $time);
      end
    end
    prev_we  <= mem_chip_en && mem_read_write;
    prev_rst <= rst;
    prev_a   <= mem_address;
    prev_d   <= mem_data_in;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];   // {rdata, last}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] len;
    int         stall;      // cycles rsp_ready is held low at the first response
    int         exp_lat;    // cycles from accept edge to first rsp_valid
    bit         chk_first;
    logic [7:0] exp_first;  // expected rsp_rdata of the first response
  } vec_t;

  function automatic int beats_of(input logic [3:0] len);
    return BURST ? int'(len) + 1 : 1;
  endfunction

  function automatic vec_t mk(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [3:0] len, input int stall, input bit chk,
                              input logic [7:0] first);
    vec_t v;
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.len       = len;
    v.stall     = stall;
    v.exp_lat   = wr ? 2 * beats_of(len) + 1 : 2;
    v.chk_first = chk;
    v.exp_first = first;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_cmd(input vec_t v);
    int beats, nrsp, k, got, hold;
    bit seen;
    logic [7:0] ai, held_d;
    logic [8:0] e;
    logic held_l;
    beats = beats_of(v.len);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_len   = v.len;
    rsp_ready = (v.stall == 0);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (v.wr) begin
      for (int i = 0; i < beats; i++) begin
        ai = v.addr + 8'(i);
        ref_mem[ai] = v.wdata;
      end
      exp_q.push_back({8'h00, 1'b1});
      nrsp = 1;
    end else begin
      for (int i = 0; i < beats; i++) begin
        ai = v.addr + 8'(i);
        exp_q.push_back({ref_mem[ai], (i == beats - 1)});
      end
      nrsp = beats;
    end
    #1 req_valid = 1'b0;
    k = 0; got = 0; hold = 0; seen = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (got < nrsp && k < 200) begin
      @(negedge clk);
      k++;
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("first_latency", 32'(k), 32'(v.exp_lat));
        end else if (v.stall == 0) begin
          check("beat_spacing", 32'(k), 32'(v.exp_lat + 2 * got));
        end
        check("rsp_req_ready_low", 32'(req_ready), 32'd0);
        check("rsp_mem_idle", {22'd0, mem_chip_en, mem_read_write, mem_address}, 32'd0);
        if (!rsp_ready) begin
          hold++;
          if (hold == 1) begin
            held_d = rsp_rdata;
            held_l = rsp_last;
          end else begin
            check("stall_rdata_stable", 32'(rsp_rdata), 32'(held_d));
            check("stall_last_stable", 32'(rsp_last), 32'(held_l));
          end
          if (hold >= v.stall) rsp_ready = 1'b1;
        end
        if (rsp_ready) begin
          if (got == 0 && v.chk_first) check("first_rdata", 32'(rsp_rdata), 32'(v.exp_first));
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", 32'(rsp_rdata), 32'(e[8:1]));
            check("rsp_last", 32'(rsp_last), 32'(e[0]));
          end
          got++;
        end
      end
    end
    if (got < nrsp) check("rsp_timeout", 32'(got), 32'(nrsp));
    @(negedge clk);
    check("next_accept_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];
  int   nwr, target, k;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_last, |rsp_rdata}, 32'd0);
    check("rst_mem_ctl", {30'd0, mem_chip_en, mem_read_write}, 32'd0);
    check("rst_mem_bus", {16'd0, mem_address, mem_data_in}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed and random command vectors
    vecs.push_back(mk(1'b1, 8'h10, 8'hA5, 4'd0, 0, 1'b1, 8'h00));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 4'd0, 0, 1'b1, 8'hA5));
    vecs.push_back(mk(1'b1, 8'hFE, 8'h3C, 4'd2, 0, 1'b1, 8'h00));
    vecs.push_back(mk(1'b0, 8'hFE, 8'h00, 4'd2, 0, 1'b1, 8'h3C));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 4'd0, 5, 1'b1, 8'hA5));
    vecs.push_back(mk(1'b0, 8'h33, 8'h00, 4'd7, 0, 1'b1, 8'h69));
    vecs.push_back(mk(1'b1, 8'hFF, 8'h81, 4'd0, 0, 1'b1, 8'h00));
    vecs.push_back(mk(1'b0, 8'hFF, 8'h00, 4'd0, 0, 1'b1, 8'h81));
    vecs.push_back(mk(1'b0, 8'hFD, 8'h00, 4'd3, 3, 1'b0, 8'h00));
    for (int i = 0; i < vecs.size(); i++) do_cmd(vecs[i]);

    // Reset during a write: 3rd beat of a 4-beat burst, or the only beat
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 8'h77; req_len = 4'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    target = BURST ? 3 : 1;
    nwr = 0; k = 0;
    while (nwr < target && k < 50) begin
      @(negedge clk);
      k++;
      if (mem_chip_en && mem_read_write) nwr++;
    end
    check("wr_beats_before_rst", 32'(nwr), 32'(target));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp", {30'd0, rsp_valid, req_ready}, 32'd0);
    check("midrst_mem", {14'd0, mem_chip_en, mem_read_write, mem_address, mem_data_in}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < nwr) ref_mem[8'h40 + 8'(i)] = 8'h77;
    end
    for (int i = 0; i < 4; i++)
      do_cmd(mk(1'b0, 8'h40 + 8'(i), 8'h00, 4'd0, 0, 1'b1,
                (i < target) ? 8'h77 : init_val(8'h40 + 8'(i))));

    // Random traffic
    for (int i = 0; i < 8; i++)
      do_cmd(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 4'($urandom_range(0, 3)),
                $urandom_range(0, 2), 1'b0, 8'h00));

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("pin_timing_viol", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
